// File: rtl/uart_frame_sched.sv
// uart_frame_sched: round-robin arbiter that frames a granted 16-bit word as SYNC, ID, low, high bytes for a UART.
module uart_frame_sched #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [7:0] ID0 = 8'h01,
    parameter logic [7:0] ID1 = 8'h02
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [15:0] din0,
    input  logic [15:0] din1,
    output logic [1:0]  gnt,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
    state_t state, state_n;
    logic [1:0] idx;
    logic [15:0] hold;
    logic cur, last, pick, grant, advance;
    logic [7:0] next_byte;
    always_comb begin
        pick = (req == 2'b11) ? ~last : req[1];
        grant = !rst && state == IDLE && |req;
        advance = !rst && state == WAIT && tx_done;
        next_byte = (idx == 2'd0) ? (cur ? ID1 : ID0) : (idx == 2'd1) ? hold[7:0] : hold[15:8];
        gnt = grant ? (pick ? 2'b10 : 2'b01) : 2'b00;
        tx_start = !rst && state == SEND;
        busy = state != IDLE;
        state_n = rst ? IDLE : grant ? SEND : (state == SEND) ? WAIT :
                  advance ? ((idx == 2'd3) ? IDLE : SEND) : state;
    end
    // tx_data is loaded on the edge entering SEND, so it is stable from tx_start until its tx_done
    always_ff @(posedge clk) begin
        state <= state_n;
        if (rst) begin
            idx <= 2'd0;
            hold <= 16'h0000;
            tx_data <= 8'h00;
            cur <= 1'b0;
            last <= 1'b1;
        end else if (grant) begin
            idx <= 2'd0;
            hold <= pick ? din1 : din0;
            cur <= pick;
            last <= pick;
            tx_data <= SYNC_BYTE;
        end else if (advance && idx != 2'd3) begin
            idx <= idx + 2'd1;
            tx_data <= next_byte;
        end
    end
endmodule

// File: tb/tb_uart_frame_sched.sv
// tb_uart_frame_sched: directed scenario tasks with hand-computed frames for uart_frame_sched.
module tb_uart_frame_sched;
    logic clk = 0, rst = 1, tx_done = 0, tx_start, busy;
    logic [1:0] req = 2'b00, gnt;
    logic [15:0] din0 = 16'h0000, din1 = 16'h0000;
    logic [7:0] tx_data;
    int checks = 0, failures = 0, cyc = 0, cnt = 0, dly = 5, overlap = 0, unstable = 0;
    bit auto_en = 1, force_done = 0;
    logic [7:0] bytes[$];
    int scyc[$];
    logic [7:0] last_byte = 8'h00;

    uart_frame_sched dut (.clk(clk), .rst(rst), .req(req), .din0(din0), .din1(din1), .gnt(gnt),
                          .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done), .busy(busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART model: tx_done arrives dly cycles after each tx_start, or when a test forces it
    initial forever begin
        @(posedge clk);
        #1 tx_done = (auto_en && cnt == 1) || force_done;
    end

    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            bytes.push_back(tx_data);
            scyc.push_back(cyc);
            last_byte <= tx_data;
        end
        if (gnt !== 2'b00 && tx_start === 1'b1) overlap <= overlap + 1;
        if (busy === 1'b1 && tx_start === 1'b0 && rst === 1'b0 && tx_data !== last_byte) unstable <= unstable + 1;
        cnt <= !auto_en ? 0 : (tx_start === 1'b1) ? dly : (cnt > 0) ? cnt - 1 : 0;
    end

    task automatic wait_gnt(output logic [1:0] g, output int c);
        g = 2'b00;
        c = 0;
        for (int i = 0; i < 200 && g == 2'b00; i++) begin
            @(negedge clk);
            if (gnt !== 2'b00) begin
                g = gnt;
                c = cyc;
            end
        end
        if (g == 2'b00) begin
            checks++;
            failures++;
            $display("FAIL wait_gnt timeout got=%b want=nonzero", gnt);
        end
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            done = (busy === 1'b0);
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL wait_idle timeout got busy=%b want=0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        req = 2'b11;
        din0 = 16'h1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b want=00", gnt); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b want=0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        @(posedge clk);
        #1 rst = 0;
        req = 2'b00;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b want=0", busy); end
    endtask

    task automatic test_single();
        logic [1:0] g;
        int c;
        logic [7:0] exp [4] = '{8'hA5, 8'h01, 8'h34, 8'h12};
        bytes.delete();
        @(posedge clk);
        #1 req = 2'b01;
        din0 = 16'h1234;
        wait_gnt(g, c);
        checks++; if (g !== 2'b01) begin failures++; $display("FAIL single_gnt got=%b want=01", g); end
        @(posedge clk);
        #1 req = 2'b00;
        wait_idle();
        checks++; if (bytes.size() != 4) begin failures++; $display("FAIL single_count got=%0d want=4", bytes.size()); end
        for (int i = 0; i < 4 && i < bytes.size(); i++) begin
            checks++; if (bytes[i] !== exp[i]) begin failures++; $display("FAIL single_byte%0d got=%h want=%h", i, bytes[i], exp[i]); end
        end
        @(negedge clk);
        checks++; if (gnt !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL single_after got gnt=%b busy=%b want 00/0", gnt, busy); end
    endtask

    task automatic test_contention();
        logic [1:0] g;
        int c;
        logic [7:0] ids [4] = '{8'h01, 8'h02, 8'h01, 8'h02};
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        bytes.delete();
        req = 2'b11;
        din0 = 16'h1234;
        din1 = 16'hABCD;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(g, c);
            checks++; if (g !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin failures++; $display("FAIL contention_gnt%0d got=%b", k, g); end
        end
        @(posedge clk);
        #1 req = 2'b00;
        wait_idle();
        checks++; if (bytes.size() != 16) begin failures++; $display("FAIL contention_count got=%0d want=16", bytes.size()); end
        for (int k = 0; k < 4 && 4 * k + 3 < bytes.size(); k++) begin
            checks++; if (bytes[4*k+1] !== ids[k]) begin failures++; $display("FAIL contention_id%0d got=%h want=%h", k, bytes[4*k+1], ids[k]); end
            checks++; if (bytes[4*k+2] !== ((k % 2 == 0) ? 8'h34 : 8'hCD)) begin failures++; $display("FAIL contention_lo%0d got=%h", k, bytes[4*k+2]); end
        end
    endtask

    task automatic test_data_change();
        logic [1:0] g;
        int c;
        bytes.delete();
        @(posedge clk);
        #1 req = 2'b01;
        din0 = 16'h1234;
        wait_gnt(g, c);
        @(posedge clk);
        #1 req = 2'b00;
        din0 = 16'hFFFF;
        wait_idle();
        checks++; if (bytes.size() != 4) begin failures++; $display("FAIL datachg_count got=%0d want=4", bytes.size()); end
        if (bytes.size() == 4) begin
            checks++; if (bytes[2] !== 8'h34) begin failures++; $display("FAIL datachg_lo got=%h want=34", bytes[2]); end
            checks++; if (bytes[3] !== 8'h12) begin failures++; $display("FAIL datachg_hi got=%h want=12", bytes[3]); end
        end
    endtask

    task automatic test_spurious();
        logic [1:0] g;
        int c;
        bytes.delete();
        auto_en = 0;
        @(negedge clk);
        force_done = 1;
        @(posedge clk);
        #2 force_done = 0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || tx_start !== 1'b0) begin failures++; $display("FAIL spur_idle got busy=%b tx_start=%b want 0/0", busy, tx_start); end
        repeat (2) @(negedge clk);
        checks++; if (bytes.size() != 0) begin failures++; $display("FAIL spur_idle_bytes got=%0d want=0", bytes.size()); end
        @(posedge clk);
        #1 req = 2'b01;
        din0 = 16'h4321;
        wait_gnt(g, c);
        force_done = 1;
        @(posedge clk);
        #2 force_done = 0;
        req = 2'b00;
        @(negedge clk);
        checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL spur_send_start got=%b want=1", tx_start); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1 || tx_start !== 1'b0) begin failures++; $display("FAIL spur_wait got busy=%b tx_start=%b want 1/0", busy, tx_start); end
        checks++; if (bytes.size() != 1) begin failures++; $display("FAIL spur_send_bytes got=%0d want=1", bytes.size()); end
        auto_en = 1;
        force_done = 1;
        @(posedge clk);
        #2 force_done = 0;
        wait_idle();
        checks++; if (bytes.size() != 4) begin failures++; $display("FAIL spur_count got=%0d want=4", bytes.size()); end
        if (bytes.size() == 4) begin
            checks++; if (bytes[3] !== 8'h43) begin failures++; $display("FAIL spur_hi got=%h want=43", bytes[3]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] g;
        int c;
        logic [7:0] exp [4] = '{8'hA5, 8'h02, 8'hBC, 8'h9A};
        bytes.delete();
        @(posedge clk);
        #1 req = 2'b01;
        din0 = 16'h5678;
        wait_gnt(g, c);
        @(posedge clk);
        #1 req = 2'b00;
        for (int i = 0; i < 100 && bytes.size() < 2; i++) @(negedge clk);
        @(posedge clk);
        #1 rst = 1;
        auto_en = 0;
        @(negedge clk);
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL rstmid_start got=%b want=0", tx_start); end
        @(posedge clk);
        #1 rst = 0;
        bytes.delete();
        @(negedge clk);
        checks++; if (tx_data !== 8'h00 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_regs got tx_data=%h busy=%b want 00/0", tx_data, busy); end
        checks++; if (gnt !== 2'b00 || tx_start !== 1'b0) begin failures++; $display("FAIL rstmid_pulses got gnt=%b tx_start=%b want 00/0", gnt, tx_start); end
        auto_en = 1;
        @(posedge clk);
        #1 req = 2'b10;
        din1 = 16'h9ABC;
        wait_gnt(g, c);
        checks++; if (g !== 2'b10) begin failures++; $display("FAIL rstmid_gnt got=%b want=10", g); end
        @(posedge clk);
        #1 req = 2'b00;
        wait_idle();
        checks++; if (bytes.size() != 4) begin failures++; $display("FAIL rstmid_count got=%0d want=4", bytes.size()); end
        for (int i = 0; i < 4 && i < bytes.size(); i++) begin
            checks++; if (bytes[i] !== exp[i]) begin failures++; $display("FAIL rstmid_byte%0d got=%h want=%h", i, bytes[i], exp[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] g1, g2;
        int c1, c2;
        dly = 1;
        bytes.delete();
        scyc.delete();
        @(posedge clk);
        #1 req = 2'b01;
        din0 = 16'hCAFE;
        wait_gnt(g1, c1);
        wait_gnt(g2, c2);
        @(posedge clk);
        #1 req = 2'b00;
        wait_idle();
        dly = 5;
        checks++; if (g2 !== 2'b01) begin failures++; $display("FAIL b2b_gnt2 got=%b want=01", g2); end
        checks++; if (c2 - c1 != 9) begin failures++; $display("FAIL b2b_gap got=%0d want=9", c2 - c1); end
        checks++; if (scyc.size() != 8) begin failures++; $display("FAIL b2b_starts got=%0d want=8", scyc.size()); end
        if (scyc.size() >= 4) begin
            checks++; if (scyc[0] - c1 != 1) begin failures++; $display("FAIL b2b_latency got=%0d want=1", scyc[0] - c1); end
            checks++; if (scyc[3] - c1 != 7) begin failures++; $display("FAIL b2b_last_start got=%0d want=7", scyc[3] - c1); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_data_change();
        test_spurious();
        test_reset_mid();
        test_back_to_back();
        @(negedge clk);
        checks++; if (overlap != 0) begin failures++; $display("FAIL gnt_tx_start_overlap got=%0d want=0", overlap); end
        checks++; if (unstable != 0) begin failures++; $display("FAIL tx_data_stability got=%0d want=0", unstable); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
